pipeline_param: RTL and testbench

Parametrised three-stage (ID/EX/WB) in-order datapath. It generalises the 8-bit, 4-register pipeline to NREG registers of DW bits, and adds a valid/ready instruction handshake, hazard handling, a sticky overflow flag and a retirement counter. It sits behind the instruction source. The register file is observed through a combinational debug read port.

---
 rtl/pipeline_param_pkg.sv | 49 ++++
 rtl/pipe_regfile.sv | 34 +++
 rtl/pipeline_param.sv | 152 +++++++++++++++
 tb/tb_pipeline_param.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_param_pkg.sv
// Shared types and instruction-field helpers for the pipeline_param datapath.
// Struct fields are sized for the widest supported build; modules slice/cast to their own widths.
package pipeline_param_pkg;

   localparam int unsigned MAX_AW = 8;
   localparam int unsigned MAX_DW = 64;
   localparam int unsigned MAX_IW = 2 + 3 * MAX_AW;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SET  = 2'b01,
      OP_NAND = 2'b10,
      OP_NOP  = 2'b11
   } op_e;

   typedef struct packed {
      logic              valid;
      op_e               op;
      logic [MAX_AW-1:0] rd;
      logic [MAX_DW-1:0] a;
      logic [MAX_DW-1:0] b;
   } stage_t;

   // Instruction layout is {op, rd, rs1, rs2}; idx 0 = rs2, 1 = rs1, 2 = rd.
   function automatic logic [MAX_AW-1:0] inst_field(input logic [MAX_IW-1:0] i,
                                                    input int unsigned aw,
                                                    input int unsigned idx);
      logic [MAX_IW-1:0] s;
      logic [MAX_IW-1:0] m;
      s = i >> (idx * aw);
      m = (MAX_IW'(1) << aw) - MAX_IW'(1);
      return MAX_AW'(s & m);
   endfunction

   function automatic op_e inst_op(input logic [MAX_IW-1:0] i, input int unsigned aw);
      logic [MAX_IW-1:0] s;
      s = i >> (3 * aw);
      return op_e'(2'(s));
   endfunction

   function automatic logic op_writes(input op_e op);
      return op != OP_NOP;
   endfunction

   function automatic logic op_reads(input op_e op);
      return (op == OP_ADD) || (op == OP_NAND);
   endfunction

endpackage

// File: rtl/pipe_regfile.sv
// NREG x DW register file: two combinational read ports, one debug read port, one write port.
module pipe_regfile #(
   parameter int unsigned NREG = 4,
   parameter int unsigned DW   = 8,
   localparam int unsigned AW  = $clog2(NREG)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   output logic [DW-1:0] rdata_a_o,
   input  logic [AW-1:0] raddr_b_i,
   output logic [DW-1:0] rdata_b_o,
   input  logic [AW-1:0] dbg_raddr_i,
   output logic [DW-1:0] dbg_rdata_o
);

   logic [DW-1:0] mem_q [NREG];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o   = mem_q[raddr_a_i];
   assign rdata_b_o   = mem_q[raddr_b_i];
   assign dbg_rdata_o = mem_q[dbg_raddr_i];

endmodule

// File: rtl/pipeline_param.sv
// Three-stage ID/EX/WB datapath with a valid/ready instruction intake.
// Define PIPELINE_PARAM_FORWARD_EN to bypass EX/WB results into ID instead of interlocking.
module pipeline_param
   import pipeline_param_pkg::*;
#(
   parameter int unsigned NREG  = 4,
   parameter int unsigned DW    = 8,
   parameter int unsigned CNT_W = 16,
   localparam int unsigned AW   = $clog2(NREG),
   localparam int unsigned IW   = 2 + 3 * AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IW-1:0]    inst,
   input  logic             inst_valid,
   output logic             inst_ready,
   input  logic [AW-1:0]    dbg_raddr,
   output logic [DW-1:0]    dbg_rdata,
   output logic             ovf,
   output logic [CNT_W-1:0] ret_cnt
);

   logic             id_valid_q, id_valid_d;
   logic [IW-1:0]    id_inst_q, id_inst_d;
   stage_t           ex_q, ex_d, wb_q, wb_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

   op_e               id_op;
   logic [MAX_AW-1:0] id_rd, id_rs1, id_rs2;
   logic [DW-1:0]     rf_a, rf_b, opa, opb;
   logic [DW-1:0]     ex_a, ex_b, ex_res;
   logic [DW:0]       ex_sum;
   logic              ex_wr, wb_wr, id_src, rf_we, stall;
   logic              ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;

   assign id_op  = inst_op(MAX_IW'(id_inst_q), AW);
   assign id_rd  = inst_field(MAX_IW'(id_inst_q), AW, 2);
   assign id_rs1 = inst_field(MAX_IW'(id_inst_q), AW, 1);
   assign id_rs2 = inst_field(MAX_IW'(id_inst_q), AW, 0);

   assign rf_we = wb_q.valid && op_writes(wb_q.op);

   pipe_regfile #(
      .NREG (NREG),
      .DW   (DW)
   ) u_regfile (
      .clk_i       (clk),
      .rst_ni      (rst),
      .we_i        (rf_we),
      .waddr_i     (AW'(wb_q.rd)),
      .wdata_i     (DW'(wb_q.a)),
      .raddr_a_i   (AW'(id_rs1)),
      .rdata_a_o   (rf_a),
      .raddr_b_i   (AW'(id_rs2)),
      .rdata_b_o   (rf_b),
      .dbg_raddr_i (dbg_raddr),
      .dbg_rdata_o (dbg_rdata)
   );

   // RAW detection: only ADD/NAND sources against writing instructions ahead of ID.
   assign ex_wr    = ex_q.valid && op_writes(ex_q.op);
   assign wb_wr    = wb_q.valid && op_writes(wb_q.op);
   assign id_src   = id_valid_q && op_reads(id_op);
   assign ex_hit_a = id_src && ex_wr && (ex_q.rd == id_rs1);
   assign ex_hit_b = id_src && ex_wr && (ex_q.rd == id_rs2);
   assign wb_hit_a = id_src && wb_wr && (wb_q.rd == id_rs1);
   assign wb_hit_b = id_src && wb_wr && (wb_q.rd == id_rs2);

   assign ex_a   = DW'(ex_q.a);
   assign ex_b   = DW'(ex_q.b);
   assign ex_sum = {1'b0, ex_a} + {1'b0, ex_b};

   always_comb begin
      ex_res = '0;
      unique case (ex_q.op)
         OP_ADD:  ex_res = DW'(ex_sum);
         OP_SET:  ex_res = ex_a;
         OP_NAND: ex_res = ~(ex_a & ex_b);
         OP_NOP:  ex_res = '0;
      endcase
   end

`ifdef PIPELINE_PARAM_FORWARD_EN
   // EX is younger than WB, so it takes priority when both match.
   always_comb begin
      opa   = ex_hit_a ? ex_res : (wb_hit_a ? DW'(wb_q.a) : rf_a);
      opb   = ex_hit_b ? ex_res : (wb_hit_b ? DW'(wb_q.a) : rf_b);
      stall = 1'b0;
   end
`else
   always_comb begin
      opa   = rf_a;
      opb   = rf_b;
      stall = ex_hit_a || ex_hit_b || wb_hit_a || wb_hit_b;
   end
`endif

   assign inst_ready = !stall;

   always_comb begin
      id_valid_d = id_valid_q;
      id_inst_d  = id_inst_q;
      if (inst_ready) begin
         id_valid_d = inst_valid;
         id_inst_d  = inst;
      end

      ex_d       = '0;
      ex_d.valid = id_valid_q && !stall;
      ex_d.op    = id_op;
      ex_d.rd    = id_rd;
      ex_d.a     = MAX_DW'(opa);
      ex_d.b     = MAX_DW'(opb);
      if (id_op == OP_SET) ex_d.a = MAX_DW'({AW'(id_rs1), AW'(id_rs2)});

      wb_d       = '0;
      wb_d.valid = ex_q.valid;
      wb_d.op    = ex_q.op;
      wb_d.rd    = ex_q.rd;
      wb_d.a     = MAX_DW'(ex_res);

      ovf_d     = ovf_q || (ex_q.valid && (ex_q.op == OP_ADD) && ex_sum[DW]);
      ret_cnt_d = ret_cnt_q + CNT_W'(rf_we);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_valid_q <= 1'b0;
         id_inst_q  <= '0;
         ex_q       <= '0;
         wb_q       <= '0;
         ovf_q      <= 1'b0;
         ret_cnt_q  <= '0;
      end else begin
         id_valid_q <= id_valid_d;
         id_inst_q  <= id_inst_d;
         ex_q       <= ex_d;
         wb_q       <= wb_d;
         ovf_q      <= ovf_d;
         ret_cnt_q  <= ret_cnt_d;
      end
   end

   assign ovf     = ovf_q;
   assign ret_cnt = ret_cnt_q;

   // Stage structs are sized for the widest build; bits above AW/DW are intentionally dropped.
   logic unused_bits;
   assign unused_bits = ^{ex_q, wb_q, id_rd, id_rs1, id_rs2};

endmodule

// File: tb/tb_pipeline_param.sv
// Directed bench for pipeline_param (NREG=4, DW=8): inst = {op[7:6], rd[5:4], rs1[3:2], rs2[1:0]}.
module tb_pipeline_param;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  inst;
   logic        inst_valid;
   logic        inst_ready;
   logic [1:0]  dbg_raddr;
   logic [7:0]  dbg_rdata;
   logic        ovf;
   logic [15:0] ret_cnt;

   int n_vec = 0;
   int n_err = 0;

`ifdef PIPELINE_PARAM_FORWARD_EN
   localparam int EXP_STALL = 0;
`else
   localparam int EXP_STALL = 2;
`endif

   always #5 clk = ~clk;

   pipeline_param #(
      .NREG  (4),
      .DW    (8),
      .CNT_W (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .inst       (inst),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .dbg_raddr  (dbg_raddr),
      .dbg_rdata  (dbg_rdata),
      .ovf        (ovf),
      .ret_cnt    (ret_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reg(input string tag, input int a, input logic [7:0] exp);
      dbg_raddr = 2'(a);
      #1;
      check_eq(tag, 32'(dbg_rdata), 32'(exp));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one instruction, waits (bounded) for ready, returns #1 after the accepting edge.
   task automatic send(input logic [7:0] i);
      int waited;
      waited     = 0;
      inst       = i;
      inst_valid = 1'b1;
      while (!inst_ready && waited < 20) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (waited >= 20) check_eq("send_timeout", 32'(waited), 32'(0));
      @(posedge clk);
      #1;
      inst_valid = 1'b0;
   endtask

   function automatic bit is_bad(input int op, input int s1, input int s2,
                                 input int p1, input int p2);
      if (!(op == 0 || op == 2)) return 1'b0;
      if (p1 >= 0 && (s1 == p1 || s2 == p1)) return 1'b1;
      if (p2 >= 0 && (s1 == p2 || s2 == p2)) return 1'b1;
      return 1'b0;
   endfunction

   logic [7:0] ovf_seq [5] = '{8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0};

   initial begin
      int n;
      logic [7:0] m_rf [4];
      logic [15:0] m_ret;
      logic m_ovf;
      int p1, p2, low;

      rst        = 1'b0;
      inst       = 8'h00;
      inst_valid = 1'b0;
      dbg_raddr  = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("ready_in_reset", 32'(inst_ready), 32'(1));
      rst = 1'b1;
      idle(1);
      check_eq("reset_ovf", 32'(ovf), 32'(0));
      check_eq("reset_ret", 32'(ret_cnt), 32'(0));
      for (int r = 0; r < 4; r++) check_reg("reset_rf", r, 8'h00);

      // SET r1,0xA; SET r2,0x7; ADD r3,r1,r2 back-to-back
      send(8'h5A);
      send(8'h67);
      send(8'h36);
      n = 0;
      repeat (5) begin
         if (!inst_ready) n++;
         @(posedge clk);
         #1;
      end
      check_eq("chain_stalls", 32'(n), 32'(EXP_STALL));
      idle(2);
      check_reg("chain_r1", 1, 8'h0A);
      check_reg("chain_r2", 2, 8'h07);
      check_reg("chain_r3", 3, 8'h11);
      check_eq("chain_ret", 32'(ret_cnt), 32'(3));

      // Doubling r0 from 0x0F; fifth ADD carries out
      send(8'h4F);
      idle(4);
      check_reg("ovf_set_r0", 0, 8'h0F);
      for (int k = 0; k < 5; k++) begin
         send(8'h00);
         idle(4);
         check_reg("ovf_add_r0", 0, ovf_seq[k]);
         check_eq("ovf_flag", 32'(ovf), 32'((k == 4) ? 1 : 0));
      end
      send(8'h90);  // NAND r1,r0,r0
      idle(4);
      check_reg("ovf_nand_r1", 1, 8'h1F);
      check_eq("ovf_sticky1", 32'(ovf), 32'(1));
      send(8'hA4);  // NAND r2,r1,r0
      idle(4);
      check_reg("ovf_nand_r2", 2, 8'hFF);
      check_eq("ovf_sticky2", 32'(ovf), 32'(1));
      check_eq("ovf_ret", 32'(ret_cnt), 32'(11));

      // Reset with three SETs in ID/EX/WB
      send(8'h75);
      send(8'h66);
      send(8'h59);
      rst = 1'b0;
      #1;
      check_eq("mid_ready_in_reset", 32'(inst_ready), 32'(1));
      idle(2);
      rst = 1'b1;
      idle(4);
      check_eq("mid_ready", 32'(inst_ready), 32'(1));
      check_eq("mid_ovf", 32'(ovf), 32'(0));
      check_eq("mid_ret", 32'(ret_cnt), 32'(0));
      for (int r = 0; r < 4; r++) check_reg("mid_rf", r, 8'h00);

      // SET r1,0xF; NAND r2,r1,r1; NOP x3
      send(8'h5F);
      send(8'hA5);
      idle(4);
      n = 0;
      repeat (3) begin
         if (!inst_ready) n++;
         send(8'hC0);
      end
      if (!inst_ready) n++;
      idle(4);
      check_eq("nop_stalls", 32'(n), 32'(0));
      check_reg("nand_r1", 1, 8'h0F);
      check_reg("nand_r2", 2, 8'hF0);
      check_eq("nop_ret", 32'(ret_cnt), 32'(2));

      // valid 1,0,1: SET r3,0x3 at edge k, bubble, SET r0,0x1 at k+2
      inst       = 8'h73;
      inst_valid = 1'b1;
      @(posedge clk); #1;            // k
      inst_valid = 1'b0;
      @(posedge clk); #1;            // k+1
      inst       = 8'h41;
      inst_valid = 1'b1;
      @(posedge clk); #1;            // k+2
      inst_valid = 1'b0;
      check_reg("gap_r3_early", 3, 8'h00);
      @(posedge clk); #1;            // k+3
      check_reg("gap_r3", 3, 8'h03);
      check_reg("gap_r0_early1", 0, 8'h00);
      @(posedge clk); #1;            // k+4
      check_reg("gap_r0_early2", 0, 8'h00);
      @(posedge clk); #1;            // k+5
      check_reg("gap_r0", 0, 8'h01);
      check_eq("gap_ret", 32'(ret_cnt), 32'(4));

      // Hazard-free random stream against an in-order reference model
      m_rf[0] = 8'h01; m_rf[1] = 8'h0F; m_rf[2] = 8'hF0; m_rf[3] = 8'h03;
      m_ret = 16'd4;
      m_ovf = 1'b0;
      p1 = -1;
      p2 = -1;
      low = 0;
      for (int t = 0; t < 1000; t++) begin
         int op, rd, s1, s2;
         logic [8:0] sum;
         op = 0; rd = 0; s1 = 0; s2 = 0;
         for (int tries = 0; tries < 50; tries++) begin
            op = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            s1 = $urandom_range(0, 3);
            s2 = $urandom_range(0, 3);
            if (!is_bad(op, s1, s2, p1, p2)) break;
         end
         if (is_bad(op, s1, s2, p1, p2)) op = 1;
         inst       = {2'(op), 2'(rd), 2'(s1), 2'(s2)};
         inst_valid = 1'b1;
         if (!inst_ready) low++;
         @(posedge clk);
         #1;
         case (op)
            0: begin
               sum = {1'b0, m_rf[s1]} + {1'b0, m_rf[s2]};
               m_rf[rd] = sum[7:0];
               if (sum[8]) m_ovf = 1'b1;
            end
            1: m_rf[rd] = {4'h0, 2'(s1), 2'(s2)};
            2: m_rf[rd] = ~(m_rf[s1] & m_rf[s2]);
            default: ;
         endcase
         if (op != 3) m_ret++;
         p2 = p1;
         p1 = (op != 3) ? rd : -1;
      end
      inst_valid = 1'b0;
      idle(4);
      check_eq("rand_ready_low", 32'(low), 32'(0));
      check_eq("rand_ret", 32'(ret_cnt), 32'(m_ret));
      check_eq("rand_ovf", 32'(ovf), 32'(m_ovf));
      for (int r = 0; r < 4; r++) check_reg("rand_rf", r, m_rf[r]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
